// File: rtl/proc_pkg.sv
// Shared types and constants for the sequencer that feeds the 4-register multicycle processor.
package proc_pkg;

  localparam int unsigned DATAWIDTH_DFLT = 6;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StExec,
    StError
  } state_e;

  localparam logic [1:0] OP_MV  = 2'b00;
  localparam logic [1:0] OP_MVI = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

endpackage

// File: rtl/prog_ram.sv
// Program memory: synchronous write, asynchronous read, contents not reset.
module prog_ram #(
  parameter int unsigned DATAWIDTH = 6,
  parameter int unsigned ADDR_W    = 4
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    waddr_i,
  input  logic [DATAWIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]    raddr_i,
  output logic [DATAWIDTH-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATAWIDTH-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_sequencer.sv
// Issues program words to the processor over its DIN/Run/Done handshake, halts at the programmed
// length and raises Error if the processor never completes an instruction.
module prog_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DATAWIDTH_DFLT,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned WDOG_MAX  = 3
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 LoadEn,
  input  logic [ADDR_W-1:0]    LoadAddr,
  input  logic [DATAWIDTH-1:0] LoadData,
  input  logic [ADDR_W:0]      ProgLen,
  input  logic                 Start,
  input  logic                 Done,
  output logic [DATAWIDTH-1:0] DIN,
  output logic                 Run,
  output logic [ADDR_W-1:0]    PC,
  output logic                 Busy,
  output logic                 Halted,
  output logic                 Error
);

  localparam int unsigned WdogW = (WDOG_MAX > 1) ? $clog2(WDOG_MAX + 1) : 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [1:0]          op_q, op_d;
  logic [WdogW-1:0]    wdog_q, wdog_d;
  logic                halted_q, halted_d;
  logic                error_q, error_d;

  logic [ADDR_W-1:0]    rd_addr;
  logic [DATAWIDTH-1:0] rd_data;
  logic [ADDR_W:0]      next_pc;
  logic                 running;

  assign running = (state_q == StIssue) || (state_q == StExec);

  // During an mvi EXEC the processor consumes the immediate word that follows the opcode.
  assign rd_addr = ((state_q == StExec) && (op_q == OP_MVI)) ? pc_q + ADDR_W'(1) : pc_q;

  prog_ram #(
    .DATAWIDTH (DATAWIDTH),
    .ADDR_W    (ADDR_W)
  ) u_prog_ram (
    .clk_i   (Clock),
    .we_i    (LoadEn && !running),
    .waddr_i (LoadAddr),
    .wdata_i (LoadData),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign next_pc = {1'b0, pc_q} + ((op_q == OP_MVI) ? (ADDR_W + 1)'(2) : (ADDR_W + 1)'(1));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    op_d     = op_q;
    wdog_d   = wdog_q;
    halted_d = halted_q;
    error_d  = error_q;

    unique case (state_q)
      StIdle, StError: begin
        if (Start) begin
          halted_d = 1'b0;
          error_d  = 1'b0;
          pc_d     = '0;
          len_d    = ProgLen;
          if (ProgLen == '0) begin
            halted_d = 1'b1;
            state_d  = StIdle;
          end else begin
            state_d  = StIssue;
          end
        end
      end
      StIssue: begin
        op_d    = rd_data[DATAWIDTH-1 -: 2];
        wdog_d  = '0;
        state_d = StExec;
      end
      StExec: begin
        if (Done) begin
          if (next_pc >= len_q) begin
            halted_d = 1'b1;
            state_d  = StIdle;
          end else begin
            pc_d    = next_pc[ADDR_W-1:0];
            state_d = StIssue;
          end
        end else begin
          wdog_d = wdog_q + WdogW'(1);
          // This edge would be the WDOG_MAX-th EXEC cycle without Done.
          if (wdog_q == WdogW'(WDOG_MAX - 1)) begin
            error_d = 1'b1;
            state_d = StError;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      len_q    <= '0;
      op_q     <= OP_MV;
      wdog_q   <= '0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      op_q     <= op_d;
      wdog_q   <= wdog_d;
      halted_q <= halted_d;
      error_q  <= error_d;
    end
  end

  assign Run    = running;
  assign Busy   = running;
  assign DIN    = running ? rd_data : '0;
  assign PC     = pc_q;
  assign Halted = halted_q;
  assign Error  = error_q;

endmodule
